echo_mix: RTL and testbench

ECHO_MIX -- requirements
Module: echo_mix

---
 rtl/echo_pkg.sv | 20 ++
 rtl/delayline.sv | 44 ++++
 rtl/saturate.sv | 25 ++
 rtl/echo_mix.sv | 149 ++++++++++++++
 tb/tb_echo_mix.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/echo_pkg.sv
// echo_pkg: FSM state type and saturation limits shared by the echo mixer.
package echo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_FB,
        MUL_DRY,
        MUL_WET,
        SUM
    } state_t;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/delayline.sv
// delayline: circular sample buffer; dout is the sample written `delay` writes ago.
module delayline #(
    parameter int W         = 16,
    parameter int MAX_DELAY = 1024,
    parameter int DW        = $clog2(MAX_DELAY + 1)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic signed [W-1:0] din,
    input  logic [DW-1:0]       delay,
    output logic signed [W-1:0] dout
);

    // MAX_DELAY is a power of two so the pointers wrap for free
    localparam int AW = $clog2(MAX_DELAY);

    logic signed [W-1:0] mem [MAX_DELAY];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [DW-1:0]       filled;

    assign rptr = wptr - AW'(delay);
    assign dout = (filled < delay) ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr   <= '0;
            filled <= '0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (filled != DW'(MAX_DELAY)) begin
                filled <= filled + 1'b1;
            end
        end
    end

endmodule

// File: rtl/saturate.sv
// saturate: clamps a wide signed value into the signed W-bit range.
module saturate
    import echo_pkg::*;
#(
    parameter int IN_W = 26,
    parameter int W    = 16
)(
    input  logic signed [IN_W-1:0] din,
    output logic signed [W-1:0]    dout
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(sat_max(W));
    localparam logic signed [IN_W-1:0] LO = IN_W'(sat_min(W));

    always_comb begin
        if (din > HI) begin
            dout = W'(HI);
        end else if (din < LO) begin
            dout = W'(LO);
        end else begin
            dout = W'(din);
        end
    end

endmodule

// File: rtl/echo_mix.sv
// echo_mix: feedback and wet/dry mix for an echo, one multiplier shared over four cycles.
module echo_mix
    import echo_pkg::*;
#(
    parameter int W  = 16,
    parameter int GW = 8
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                strobe,
    input  logic signed [W-1:0] dry,
    input  logic signed [W-1:0] wet,
    input  logic [GW-1:0]       feedback,
    input  logic [GW-1:0]       mix,
    output logic signed [W-1:0] fb_out,
    output logic signed [W-1:0] out,
    output logic                valid,
    output logic                busy
);

    localparam int PW = W + GW + 1;
    localparam int AW = W + GW + 2;

    state_t state;
    state_t next;

    logic signed [W-1:0]  dry_r;
    logic signed [W-1:0]  wet_r;
    logic [GW-1:0]        fb_r;
    logic [GW-1:0]        mix_r;
    logic signed [AW-1:0] fb_acc;
    logic signed [AW-1:0] mix_acc;
    logic signed [AW-1:0] mix_shift;
    logic signed [W-1:0]  fb_sat;
    logic signed [W-1:0]  out_sat;

    logic signed [W-1:0]  mul_a;
    logic [GW-1:0]        mul_g;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;

    // gain is unsigned, so it enters the signed multiplier with a zero sign bit
    assign a_ext = PW'(mul_a);
    assign g_ext = PW'($signed({1'b0, mul_g}));
    assign prod  = a_ext * g_ext;

    assign busy      = (state != IDLE);
    assign mix_shift = mix_acc >>> GW;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next  = state;
        mul_a = wet_r;
        mul_g = fb_r;
        unique case (state)
            IDLE: begin
                if (strobe) begin
                    next = MUL_FB;
                end
            end
            MUL_FB: begin
                next = MUL_DRY;
            end
            MUL_DRY: begin
                next  = MUL_WET;
                mul_a = dry_r;
                mul_g = mix_r;
            end
            MUL_WET: begin
                next  = SUM;
                mul_g = mix_r;
            end
            SUM: begin
                next = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    // dry*(2^GW - mix) is formed as dry<<GW - dry*mix to keep the gain in GW bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dry_r   <= '0;
            wet_r   <= '0;
            fb_r    <= '0;
            mix_r   <= '0;
            fb_acc  <= '0;
            mix_acc <= '0;
            fb_out  <= '0;
            out     <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (strobe) begin
                        dry_r <= dry;
                        wet_r <= wet;
                        fb_r  <= feedback;
                        mix_r <= mix;
                    end
                end
                MUL_FB: begin
                    fb_acc <= AW'(dry_r) + AW'(prod >>> GW);
                end
                MUL_DRY: begin
                    mix_acc <= (AW'(dry_r) <<< GW) - AW'(prod);
                end
                MUL_WET: begin
                    mix_acc <= mix_acc + AW'(prod);
                end
                SUM: begin
                    fb_out <= fb_sat;
                    out    <= out_sat;
                    valid  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    saturate #(
        .IN_W(AW),
        .W   (W)
    ) u_sat_fb (
        .din (fb_acc),
        .dout(fb_sat)
    );

    saturate #(
        .IN_W(AW),
        .W   (W)
    ) u_sat_out (
        .din (mix_shift),
        .dout(out_sat)
    );

endmodule

// File: tb/tb_echo_mix.sv
// tb_echo_mix: directed table, random vectors against a floor-division model, and a closed echo loop.
module tb_echo_mix;

    localparam int W  = 16;
    localparam int GW = 8;

    typedef struct {
        int dry;
        int wet;
        int fb;
        int mix;
        int exp_fb;
        int exp_out;
    } vec_t;

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                strobe    = 1'b0;
    logic signed [W-1:0] dry       = '0;
    logic signed [W-1:0] wet_drv   = '0;
    logic [GW-1:0]       feedback  = '0;
    logic [GW-1:0]       mix       = '0;
    logic                loop_mode = 1'b0;
    logic [10:0]         dl_delay  = 11'd4;
    logic signed [W-1:0] wet_in;
    logic signed [W-1:0] dl_dout;
    logic signed [W-1:0] fb_out;
    logic signed [W-1:0] out;
    logic                valid;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign wet_in = loop_mode ? dl_dout : wet_drv;

    echo_mix #(.W(W), .GW(GW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe  (strobe),
        .dry     (dry),
        .wet     (wet_in),
        .feedback(feedback),
        .mix     (mix),
        .fb_out  (fb_out),
        .out     (out),
        .valid   (valid),
        .busy    (busy)
    );

    delayline #(.W(W), .MAX_DELAY(1024)) dl (
        .clk  (clk),
        .rst_n(rst_n),
        .wr_en(valid),
        .din  (fb_out),
        .delay(dl_delay),
        .dout (dl_dout)
    );

    function automatic longint fdiv(input longint a);
        longint d;
        longint q;
        d = longint'(1) << GW;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(input longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint ref_fb(input longint d, input longint w, input longint f);
        return sat(d + fdiv(w * f));
    endfunction

    function automatic longint ref_out(input longint d, input longint w, input longint m);
        return sat(fdiv(d * ((longint'(1) << GW) - m) + w * m));
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input int d, input int w, input int f,
                       input int m, input longint efb, input longint eout);
        int vcount;
        int vfirst;
        vcount   = 0;
        vfirst   = -1;
        dry      = W'(d);
        wet_drv  = W'(w);
        feedback = GW'(f);
        mix      = GW'(m);
        strobe   = 1'b1;
        tick;
        strobe   = 1'b0;
        dry      = W'($urandom);
        wet_drv  = W'($urandom);
        feedback = GW'($urandom);
        mix      = GW'($urandom);
        check({name, " busy"}, longint'(busy), 1);
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (valid) begin
                vcount++;
                if (vfirst < 0) vfirst = k;
            end
        end
        check({name, " latency"}, vfirst, 4);
        check({name, " pulses"}, vcount, 1);
        check({name, " fb_out"}, fb_out, efb);
        check({name, " out"}, out, eout);
    endtask

    vec_t tbl[8];

    initial begin
        int vcount;
        int vfirst;
        int got;
        longint hist[$];
        longint ew;
        longint efb;
        int d;
        int w;
        int f;
        int m;

        tbl[0] = '{1000, 2000, 128, 128, 2000, 1500};
        tbl[1] = '{30000, 30000, 255, 0, 32767, 30000};
        tbl[2] = '{0, -3, 128, 255, -2, -3};
        tbl[3] = '{-32768, -32768, 255, 255, -32768, -32768};
        tbl[4] = '{1234, -5678, 0, 0, 1234, 1234};
        tbl[5] = '{-1, 1, 1, 1, -1, -1};
        tbl[6] = '{32767, 32767, 255, 255, 32767, 32767};
        tbl[7] = '{100, -32768, 255, 128, -32540, -16334};

        rst_n = 1'b0;
        tick;
        strobe = 1'b1;
        tick;
        check("rst fb_out", fb_out, 0);
        check("rst out", out, 0);
        check("rst valid", longint'(valid), 0);
        check("rst busy", longint'(busy), 0);
        rst_n  = 1'b1;
        strobe = 1'b0;
        tick;
        check("strobe in reset ignored", longint'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("vec%0d", i), tbl[i].dry, tbl[i].wet, tbl[i].fb,
                tbl[i].mix, tbl[i].exp_fb, tbl[i].exp_out);
        end

        for (int i = 0; i < 120; i++) begin
            d = int'($signed(W'($urandom)));
            w = int'($signed(W'($urandom)));
            f = int'($urandom_range(0, 255));
            m = int'($urandom_range(0, 255));
            if (i % 10 == 0) m = 0;
            if (i % 10 == 1) f = 0;
            if (i % 10 == 2) f = 255;
            run($sformatf("rand%0d", i), d, w, f, m, ref_fb(d, w, f), ref_out(d, w, m));
        end

        // strobe while busy is dropped; inputs changed after acceptance are ignored
        dry = 16'sd1000; wet_drv = 16'sd2000; feedback = 8'd128; mix = 8'd128;
        strobe = 1'b1;
        tick;
        strobe = 1'b0;
        dry = -16'sd500; wet_drv = 16'sd7; feedback = 8'd3; mix = 8'd200;
        tick;
        strobe = 1'b1;
        tick;
        strobe = 1'b0;
        vcount = 0;
        vfirst = -1;
        for (int k = 3; k <= 12; k++) begin
            tick;
            if (valid) begin
                vcount++;
                if (vfirst < 0) vfirst = k;
            end
        end
        check("busy strobe latency", vfirst, 4);
        check("busy strobe pulses", vcount, 1);
        check("busy strobe fb_out", fb_out, 2000);
        check("busy strobe out", out, 1500);

        // reset two edges into a computation aborts it
        dry = 16'sd300; wet_drv = 16'sd400; feedback = 8'd64; mix = 8'd64;
        strobe = 1'b1;
        tick;
        strobe = 1'b0;
        tick;
        rst_n = 1'b0;
        tick;
        check("abort fb_out", fb_out, 0);
        check("abort out", out, 0);
        check("abort busy", longint'(busy), 0);
        rst_n  = 1'b1;
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (valid) vcount++;
        end
        check("abort pulses", vcount, 0);
        check("abort hold out", out, 0);
        run("after abort", 1000, 2000, 128, 128, 2000, 1500);

        // closed loop through the delay line
        rst_n     = 1'b0;
        loop_mode = 1'b1;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        for (int n = 0; n < 16; n++) begin
            d  = (n == 0) ? 16384 : 0;
            ew = (n >= 4) ? hist[n - 4] : 0;
            check($sformatf("loop wet %0d", n), wet_in, ew);
            dry      = W'(d);
            feedback = 8'd128;
            mix      = 8'd128;
            strobe   = 1'b1;
            tick;
            strobe = 1'b0;
            got    = 0;
            for (int k = 0; k < 8 && got == 0; k++) begin
                tick;
                if (valid) got = 1;
            end
            check($sformatf("loop valid %0d", n), got, 1);
            efb = ref_fb(d, ew, 128);
            hist.push_back(efb);
            check($sformatf("loop fb_out %0d", n), fb_out, efb);
            if (n == 4) check("echo 1", fb_out, 8192);
            if (n == 8) check("echo 2", fb_out, 4096);
            if (n == 12) check("echo 3", fb_out, 2048);
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
